pe_store_arbiter: RTL

PE_STORE_ARBITER -- requirements
Module: pe_store_arbiter

---
 rtl/pe_store_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/pe_store_arbiter.sv
// rtl/pe_store_arbiter.sv - round-robin store arbiter funnelling PE results into one store port (optional watchdog: STORE_TIMEOUT_EN)
module pe_store_arbiter #(
  parameter int NPE         = 4,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  STORE_START,
  input  logic [NPE-1:0]        PE_MASK,
  input  logic [ADDR_W-1:0]     BASE_ADDR,
  input  logic [NPE-1:0]        OUT_READY,
  input  logic [NPE*DATA_W-1:0] DATAIN,
  output logic [NPE-1:0]        PE_ACK,
  output logic                  WR_EN,
  output logic [ADDR_W-1:0]     WR_ADDR,
  output logic [DATA_W-1:0]     WR_DATA,
  input  logic                  WR_READY,
  output logic                  BUSY,
  output logic                  ROUND_DONE,
  output logic                  ERROR
);

  localparam int GW = (NPE > 1) ? $clog2(NPE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [NPE-1:0]    r_pending;
  logic [NPE-1:0]    r_ack;
  logic [GW-1:0]     r_ptr;
  logic [GW-1:0]     r_grant;
  logic [ADDR_W-1:0] r_addr;

  logic [NPE-1:0]    w_req;
  logic              w_found;
  logic [GW-1:0]     w_pick;
  logic [NPE-1:0]    w_grant_oh;
  logic [NPE-1:0]    w_pending_next;
  logic              w_timeout;

  // Round-robin search over eligible requests, starting at the priority pointer
  always_comb begin
    int j;
    j       = 0;
    w_req   = r_pending & OUT_READY;
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 0; i < NPE; i++) begin
      j = int'(r_ptr) + i;
      if (j >= NPE) j = j - NPE;
      if (!w_found && w_req[j]) begin
        w_found = 1'b1;
        w_pick  = GW'(j);
      end
    end
  end

  // One-hot form of the current grant, used for the ack pulse and pending clear
  always_comb begin
    w_grant_oh          = '0;
    w_grant_oh[r_grant] = 1'b1;
  end

  assign w_pending_next = r_pending & ~w_grant_oh;

`ifdef STORE_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

  logic [WAIT_W-1:0] r_wait;
  logic              w_waiting;

  // Stalled means an ARB cycle with work left but nothing to grant, or a WRITE the port refuses
  assign w_waiting = ((r_state == S_ARB) && (r_pending != '0) && !w_found) ||
                     ((r_state == S_WRITE) && !WR_READY);
  assign w_timeout = w_waiting && (r_wait == WAIT_W'(TIMEOUT_CYC - 1));

  // Consecutive stall counter, restarted whenever the FSM changes state
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wait <= '0;
    end else if (w_next != r_state) begin
      r_wait <= '0;
    end else if (w_waiting) begin
      r_wait <= r_wait + 1'b1;
    end
  end
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYC > 0);
`endif

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and store-port drive
  always_comb begin
    w_next     = r_state;
    WR_EN      = 1'b0;
    WR_ADDR    = '0;
    WR_DATA    = '0;
    BUSY       = (r_state != S_IDLE);
    ROUND_DONE = 1'b0;
    ERROR      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (STORE_START) w_next = S_ARB;
      end
      S_ARB: begin
        if (r_pending == '0) begin
          w_next = S_DONE;
        end else if (w_timeout) begin
          ERROR  = 1'b1;
          w_next = S_DONE;
        end else if (w_found) begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        WR_EN   = 1'b1;
        WR_ADDR = r_addr;
        WR_DATA = DATAIN[int'(r_grant)*DATA_W +: DATA_W];
        if (w_timeout) begin
          ERROR  = 1'b1;
          w_next = S_DONE;
        end else if (WR_READY) begin
          w_next = (w_pending_next == '0) ? S_DONE : S_ARB;
        end
      end
      S_DONE: begin
        ROUND_DONE = 1'b1;
        w_next     = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Round bookkeeping: pending set, address counter, grant, priority pointer, ack pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pending <= '0;
      r_ptr     <= '0;
      r_addr    <= '0;
      r_grant   <= '0;
      r_ack     <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (STORE_START) begin
            r_pending <= PE_MASK;
            r_addr    <= BASE_ADDR;
          end
        end
        S_ARB: begin
          if (w_timeout) begin
            r_pending <= '0;
          end else if ((r_pending != '0) && w_found) begin
            r_grant <= w_pick;
          end
        end
        S_WRITE: begin
          if (w_timeout) begin
            r_pending <= '0;
          end else if (WR_READY) begin
            r_ack     <= w_grant_oh;
            r_pending <= w_pending_next;
            r_addr    <= r_addr + 1'b1;
            r_ptr     <= (r_grant == GW'(NPE - 1)) ? '0 : r_grant + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign PE_ACK = r_ack;

endmodule
